// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and address-split helpers for data_cache
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } cache_state_e;

    // Element [0] is the most significant byte of the packed word.
    typedef logic [0:3][7:0] byte_word_t;

    localparam int unsigned OFFSET_W = 2;

    function automatic int unsigned index_w(input int unsigned num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int unsigned tag_w(input int unsigned xlen, input int unsigned num_lines);
        return xlen - $clog2(num_lines) - OFFSET_W;
    endfunction

endpackage

// File: rtl/cache_line_array.sv
// rtl/cache_line_array.sv - valid/tag/data storage, async read port, sync write port
module cache_line_array
    import cache_pkg::*;
#(
    parameter int unsigned NUM_LINES = 16,
    parameter int unsigned INDEX_W   = 4,
    parameter int unsigned TAG_W     = 26
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic [INDEX_W-1:0] rd_index_i,
    output logic               rd_valid_o,
    output logic [TAG_W-1:0]   rd_tag_o,
    output byte_word_t         rd_data_o,
    input  logic               wr_en_i,
    input  logic [INDEX_W-1:0] wr_index_i,
    input  logic [TAG_W-1:0]   wr_tag_i,
    input  byte_word_t         wr_data_i
);

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    byte_word_t           data_q [NUM_LINES];

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_tag_o   = tag_q[rd_index_i];
    assign rd_data_o  = data_q[rd_index_i];

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_index_i] <= 1'b1;
        end
    end

    // Tag and data need no reset: they are only observed through a valid bit.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_index_i]  <= wr_tag_i;
            data_q[wr_index_i] <= wr_data_i;
        end
    end

endmodule

// File: rtl/data_cache.sv
// rtl/data_cache.sv - direct-mapped write-through data cache; DCACHE_STATS_EN adds hit/miss counters
module data_cache
    import cache_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned NUM_LINES   = 16,
    parameter int unsigned MEM_LATENCY = 4
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic [XLEN-1:0] cpu_addr,
    input  logic            cpu_rd_en,
    input  logic            cpu_wr_en,
    input  byte_word_t      cpu_wdata,
    output byte_word_t      cpu_rdata,
    output logic            cpu_stall,
    output logic [XLEN-1:0] mem_addr,
    input  byte_word_t      mem_data_in,
    output byte_word_t      mem_data_out,
    output logic            mem_write_en
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]     hit_count,
    output logic [31:0]     miss_count
`endif
);

    localparam int unsigned INDEX_W = index_w(NUM_LINES);
    localparam int unsigned TAG_W   = tag_w(XLEN, NUM_LINES);
    localparam int unsigned CNT_W   = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(MEM_LATENCY);

    cache_state_e     state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  addr_q;
    byte_word_t       wdata_q;

    logic [INDEX_W-1:0] cpu_index;
    logic [TAG_W-1:0]   cpu_tag;
    logic               line_valid;
    logic [TAG_W-1:0]   line_tag;
    byte_word_t         line_data;
    logic               hit;
    logic               idle;
    logic               rd_req;
    logic               cnt_done;
    logic               unused_bits;

    logic               arr_we;
    logic [INDEX_W-1:0] arr_windex;
    logic [TAG_W-1:0]   arr_wtag;
    byte_word_t         arr_wdata;

    assign cpu_index   = cpu_addr[INDEX_W+1:2];
    assign cpu_tag     = cpu_addr[XLEN-1:INDEX_W+2];
    assign unused_bits = ^{cpu_addr[1:0], addr_q[1:0]};

    assign hit      = line_valid && (line_tag == cpu_tag);
    assign idle     = (state_q == IDLE);
    assign rd_req   = cpu_rd_en && !cpu_wr_en;
    assign cnt_done = (cnt_q == CNT_DONE);

    cache_line_array #(
        .NUM_LINES (NUM_LINES),
        .INDEX_W   (INDEX_W),
        .TAG_W     (TAG_W)
    ) u_lines (
        .clk        (clk),
        .rst_b      (rst_b),
        .rd_index_i (cpu_index),
        .rd_valid_o (line_valid),
        .rd_tag_o   (line_tag),
        .rd_data_o  (line_data),
        .wr_en_i    (arr_we),
        .wr_index_i (arr_windex),
        .wr_tag_i   (arr_wtag),
        .wr_data_i  (arr_wdata)
    );

    // One write port serves both store-hit updates and fill completion; reset blocks both.
    always_comb begin
        arr_we     = 1'b0;
        arr_windex = cpu_index;
        arr_wtag   = cpu_tag;
        arr_wdata  = cpu_wdata;
        if (rst_b) begin
            if (idle && cpu_wr_en && hit) begin
                arr_we = 1'b1;
            end else if (state_q == FILL && cnt_done) begin
                arr_we     = 1'b1;
                arr_windex = addr_q[INDEX_W+1:2];
                arr_wtag   = addr_q[XLEN-1:INDEX_W+2];
                arr_wdata  = mem_data_in;
            end
        end
    end

    assign cpu_stall    = rst_b && (!idle || cpu_wr_en || (cpu_rd_en && !hit));
    assign cpu_rdata    = (rst_b && idle && rd_req && hit) ? line_data : '0;
    assign mem_addr     = idle ? '0 : addr_q;
    assign mem_write_en = (state_q == WRITE);
    assign mem_data_out = (state_q == WRITE) ? wdata_q : '0;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cpu_wr_en) begin
                        addr_q  <= {cpu_addr[XLEN-1:2], 2'b00};
                        wdata_q <= cpu_wdata;
                        cnt_q   <= CNT_W'(1);
                        state_q <= WRITE;
                    end else if (cpu_rd_en && !hit) begin
                        addr_q  <= {cpu_addr[XLEN-1:2], 2'b00};
                        cnt_q   <= CNT_W'(1);
                        state_q <= FILL;
                    end
                end
                FILL, WRITE: begin
                    if (cnt_done) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (idle && rd_req) begin
            if (hit && hit_cnt_q != 32'hFFFF_FFFF) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end else if (!hit && miss_cnt_q != 32'hFFFF_FFFF) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_data_cache.sv
// tb/tb_data_cache.sv - directed self-checking bench for data_cache
module tb_data_cache;
    import cache_pkg::*;

    logic        clk = 1'b0;
    logic        rst_b;
    logic [31:0] cpu_addr;
    logic        cpu_rd_en;
    logic        cpu_wr_en;
    byte_word_t  cpu_wdata;
    byte_word_t  cpu_rdata;
    logic        cpu_stall;
    logic [31:0] mem_addr;
    byte_word_t  mem_data_in;
    byte_word_t  mem_data_out;
    logic        mem_write_en;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [0:255];
    int          wr_cycles;
    int          nowrite_stall;
    logic [31:0] last_wr_addr;
    logic [31:0] last_wr_data;

    always #5 clk = ~clk;

    data_cache #(
        .XLEN        (32),
        .NUM_LINES   (16),
        .MEM_LATENCY (4)
    ) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .cpu_addr     (cpu_addr),
        .cpu_rd_en    (cpu_rd_en),
        .cpu_wr_en    (cpu_wr_en),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata),
        .cpu_stall    (cpu_stall),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .mem_write_en (mem_write_en)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count    (hit_count),
        .miss_count   (miss_count)
`endif
    );

    assign mem_data_in = mem[mem_addr[9:2]];

    // Memory model: commits a store on every strobed cycle, tallies stall cycles without strobe.
    always @(negedge clk) begin
        if (rst_b) begin
            if (mem_write_en) begin
                wr_cycles    = wr_cycles + 1;
                last_wr_addr = mem_addr;
                last_wr_data = mem_data_out;
                mem[mem_addr[9:2]] = mem_data_out;
            end else if (cpu_stall) begin
                nowrite_stall = nowrite_stall + 1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_b     = 1'b0;
        cpu_rd_en = 1'b0;
        cpu_wr_en = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_b = 1'b1;
    endtask

    task automatic read_op(input string tag, input logic [31:0] a, input int exp_stall,
                           input logic [31:0] exp_data);
        int          n;
        logic [31:0] seen_addr;
        n = 0;
        seen_addr = '0;
        @(posedge clk);
        #1 cpu_addr = a;
        cpu_rd_en = 1'b1;
        @(negedge clk);
        while (cpu_stall && n < 20) begin
            n++;
            if (n == 2) seen_addr = mem_addr;
            @(negedge clk);
        end
        check_eq({tag, " stall"}, n, exp_stall);
        check_eq({tag, " rdata"}, cpu_rdata, exp_data);
        if (exp_stall > 0) check_eq({tag, " mem_addr"}, seen_addr, a);
        @(posedge clk);
        #1 cpu_rd_en = 1'b0;
    endtask

    task automatic store_op(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic also_rd);
        int n;
        n = 0;
        @(posedge clk);
        #1 cpu_addr = a;
        cpu_wdata     = d;
        cpu_wr_en     = 1'b1;
        cpu_rd_en     = also_rd;
        wr_cycles     = 0;
        nowrite_stall = 0;
        @(negedge clk);
        check_eq({tag, " accept stall"}, cpu_stall, 1'b1);
        @(posedge clk);
        #1 cpu_wr_en = 1'b0;
        cpu_rd_en = 1'b0;
        @(negedge clk);
        while (cpu_stall && n < 20) begin
            n++;
            @(negedge clk);
        end
        check_eq({tag, " wr cycles"}, wr_cycles, 4);
        check_eq({tag, " fill cycles"}, nowrite_stall, 1);
        check_eq({tag, " wr addr"}, last_wr_addr, a);
        check_eq({tag, " wr data"}, last_wr_data, d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h10] = 32'h1122_3344;
        mem[8'h20] = 32'h5566_7788;
        mem[8'h21] = 32'h99AA_BBCC;
        mem[8'h40] = 32'h0102_0304;
        wr_cycles     = 0;
        nowrite_stall = 0;
        last_wr_addr  = '0;
        last_wr_data  = '0;
        cpu_addr      = '0;
        cpu_wdata     = '0;

        do_reset();
        @(negedge clk);
        check_eq("reset stall", cpu_stall, 1'b0);
        check_eq("reset mem_write_en", mem_write_en, 1'b0);
        check_eq("reset mem_addr", mem_addr, 32'h0);
        check_eq("reset mem_data_out", mem_data_out, 32'h0);
        check_eq("reset rdata", cpu_rdata, 32'h0);
`ifdef DCACHE_STATS_EN
        check_eq("reset hit_count", hit_count, 32'h0);
        check_eq("reset miss_count", miss_count, 32'h0);
`endif

        read_op("miss 40", 32'h40, 5, 32'h1122_3344);
        read_op("hit 40", 32'h40, 0, 32'h1122_3344);
`ifdef DCACHE_STATS_EN
        check_eq("stats hit", hit_count, 32'd2);
        check_eq("stats miss", miss_count, 32'd1);
`endif

        read_op("evict 80", 32'h80, 5, 32'h5566_7788);
        read_op("evict 40", 32'h40, 5, 32'h1122_3344);
        read_op("evict 80 again", 32'h80, 5, 32'h5566_7788);

        read_op("refill 40", 32'h40, 5, 32'h1122_3344);
        store_op("store hit", 32'h40, 32'hAABB_CCDD, 1'b0);
        read_op("hit after store", 32'h40, 0, 32'hAABB_CCDD);

        store_op("rd+wr", 32'h40, 32'h1234_5678, 1'b1);
        read_op("hit after rd+wr", 32'h40, 0, 32'h1234_5678);

        do_reset();
        store_op("store miss", 32'h100, 32'hCAFE_F00D, 1'b0);
        read_op("no allocate", 32'h100, 5, 32'hCAFE_F00D);

        read_op("fill 84", 32'h84, 5, 32'h99AA_BBCC);
        @(posedge clk);
        #1 cpu_addr = 32'h40;
        cpu_rd_en = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst_b = 1'b0;
        cpu_rd_en = 1'b0;
        @(posedge clk);
        #1 rst_b = 1'b1;
        @(negedge clk);
        check_eq("mid-fill reset stall", cpu_stall, 1'b0);
        check_eq("mid-fill reset mem_addr", mem_addr, 32'h0);
`ifdef DCACHE_STATS_EN
        check_eq("mid-fill hit_count", hit_count, 32'h0);
        check_eq("mid-fill miss_count", miss_count, 32'h0);
`endif
        read_op("post-reset 84", 32'h84, 5, 32'h99AA_BBCC);
        read_op("post-reset 40", 32'h40, 5, 32'h1234_5678);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
- Direct-mapped, write-through, no-write-allocate data cache. Sits between the core's load/store port and the byte-lane data memory.
- The memory has fixed multi-cycle latency and no ready signal. The cache counts the wait itself and stalls the core with cpu_stall.
- One word per line, word-aligned accesses only.

Parameters:
- XLEN, 32, address/data width.
- NUM_LINES, 16, number of cache lines (power of two, at least 2).
- MEM_LATENCY, 4, cycles a memory read or write needs (at least 1).

Ports:
- clk  input  1  clock
- rst_b  input  1  synchronous reset, active low
- cpu_addr  input  XLEN  byte address from core; bits [1:0] ignored
- cpu_rd_en  input  1  load request
- cpu_wr_en  input  1  store request
- cpu_wdata  input  4x8 (byte array [0:3])  store data
- cpu_rdata  output  4x8 (byte array [0:3])  load data
- cpu_stall  output  1  core must hold its request and PC
- mem_addr  output  XLEN  word-aligned memory address
- mem_data_in  input  4x8 (byte array [0:3])  memory read data
- mem_data_out  output  4x8 (byte array [0:3])  memory write data
- mem_write_en  output  1  memory write strobe

Behaviour:
- Clock and reset: single clock clk. rst_b is synchronous and active low. On reset:
  - state goes to IDLE and all valid bits clear;
  - counter = 0;
  - cpu_stall = 0, mem_write_en = 0, mem_addr = 0, mem_data_out = 0;
  - cpu_rdata = 0.
- Reset mid-FILL or mid-WRITE abandons the operation; no line is updated.
- Address split: offset = [1:0]; index = [log2(NUM_LINES)+1:2]; tag = remaining upper bits.
- Hit: valid[index] and tag match.
- States: IDLE, FILL, WRITE.
- IDLE behaviour:
  - Read hit: cpu_rdata = line data combinationally, same cycle; cpu_stall = 0.
  - Read miss: cpu_stall = 1 combinationally in that cycle; latch the word address; counter = 1; go to FILL.
  - Store, hit or miss: cpu_stall = 1; latch address and data; if hit, update the line data at the same edge; counter = 1; go to WRITE.
  - No request: cpu_stall = 0; mem_write_en = 0.
- Simultaneous cpu_rd_en and cpu_wr_en: the store wins and the load is ignored.
- FILL:
  - mem_addr = latched address; cpu_stall = 1.
  - Counter increments each cycle.
  - When counter == MEM_LATENCY: capture mem_data_in into the line, set tag and valid, go to IDLE.
  - The next cycle is a hit, so read-miss latency is MEM_LATENCY + 1 cycles of stall.
- WRITE:
  - mem_addr = latched address; mem_data_out = latched data.
  - mem_write_en = 1 for all MEM_LATENCY cycles; cpu_stall = 1.
  - When counter == MEM_LATENCY: go to IDLE with mem_write_en = 0.
  - A store miss never allocates a line.
- Stall release: cpu_stall falls in the cycle the state returns to IDLE and no new miss or store is presented.
- Counter width: clog2(MEM_LATENCY+1) bits; it never wraps.
- Line overwrite: a fill evicts the previous line at that index unconditionally. Write-through means no dirty state.
- Outside states: cpu_rdata is 0 when not IDLE-hit; mem_data_out is 0 outside WRITE.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- When defined, adds two 32-bit outputs, hit_count and miss_count:
  - both reset to 0;
  - each increments once per accepted IDLE read that hits or misses respectively;
  - stores are not counted;
  - counters saturate at 32'hFFFF_FFFF.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package cache_pkg holds:
  - the state enum type (IDLE, FILL, WRITE);
  - the byte_word_t typedef (4x8 byte array);
  - localparams for the INDEX_W / TAG_W derivation.
- Sub-module: cache_line_array, holding the valid/tag/data storage with one combinational read port and one synchronous write port and valid clear on reset.
- The FSM and counter stay in data_cache.

Test Plan:
- Read miss then hit:
  - Stimulus: reset, then read 0x0000_0040; memory holds 0x11,0x22,0x33,0x44.
  - Required: cpu_stall high exactly 5 cycles (latency 4); mem_addr=0x40; then cpu_rdata = 0x11,0x22,0x33,0x44 with stall 0.
  - Repeat read: hit, zero stall.
- Conflict eviction:
  - Stimulus: read 0x40, then 0x80 (same index 0 with 16 lines, different tag), then 0x40.
  - Required: three misses, each 5 stall cycles.
- Store hit:
  - Stimulus: after filling 0x40, store 0xAA,0xBB,0xCC,0xDD to 0x40.
  - Required: mem_write_en high 4 cycles with mem_addr=0x40 and data AA..DD; following read hits returning AA..DD.
- Store miss:
  - Stimulus: store to 0x100 with a cold cache.
  - Required: memory written; subsequent read of 0x100 misses (no allocate).
- Simultaneous rd/wr:
  - Stimulus: assert cpu_rd_en and cpu_wr_en together at 0x40.
  - Required: WRITE path taken; no FILL.
- Reset mid-FILL:
  - Stimulus: assert rst_b=0 in the 2nd FILL cycle.
  - Required: next cycle cpu_stall=0, all lines invalid, and re-reading 0x40 misses.
  - With DCACHE_STATS_EN: counters read 0.
